// File: rtl/mux_scan_nto1.sv
// N-channel registered multiplexer with a manual select mode and an automatic
// scan mode that holds each channel for DWELL cycles and flags each wrap.
module mux_scan_nto1 #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 1,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned DWELL  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   d,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     mode,
  input  logic                     en,
  output logic [DATA_W-1:0]        out,
  output logic                     out_valid,
  output logic [SEL_W-1:0]         cur_sel,
  output logic                     wrap
);

  localparam int unsigned DcntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DcntW-1:0] DcntLast = DcntW'(DWELL - 1);
  localparam logic [SEL_W-1:0] PtrLast  = SEL_W'(N_CH - 1);

  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  cur_q, cur_d;
  logic              wrap_q, wrap_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DcntW-1:0]  dcnt_q, dcnt_d;
  logic              mode_q;

  logic              mode_chg;
  logic [SEL_W-1:0]  ptr_eff;
  logic [DcntW-1:0]  dcnt_eff;
  logic [SEL_W-1:0]  idx;
  logic [DATA_W-1:0] chan;
  logic              sel_ok;

  // A mode change restarts the scan from channel 0 within the same cycle.
  assign mode_chg = (mode != mode_q);
  assign ptr_eff  = mode_chg ? '0 : ptr_q;
  assign dcnt_eff = mode_chg ? '0 : dcnt_q;
  assign idx      = mode ? ptr_eff : sel;
  assign sel_ok   = (32'(sel) < N_CH);

  always_comb begin
    chan = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (idx == SEL_W'(k)) chan = d[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    out_d   = out_q;
    cur_d   = cur_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    ptr_d   = ptr_eff;
    dcnt_d  = dcnt_eff;
    if (en) begin
      if (!mode) begin
        if (sel_ok) begin
          out_d   = chan;
          cur_d   = sel;
          valid_d = 1'b1;
        end
      end else begin
        out_d   = chan;
        cur_d   = ptr_eff;
        valid_d = 1'b1;
        if (dcnt_eff == DcntLast) begin
          dcnt_d = '0;
          if (ptr_eff == PtrLast) begin
            ptr_d  = '0;
            wrap_d = 1'b1;
          end else begin
            ptr_d = ptr_eff + SEL_W'(1);
          end
        end else begin
          dcnt_d = dcnt_eff + DcntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      cur_q   <= '0;
      wrap_q  <= 1'b0;
      ptr_q   <= '0;
      dcnt_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      cur_q   <= cur_d;
      wrap_q  <= wrap_d;
      ptr_q   <= ptr_d;
      dcnt_q  <= dcnt_d;
      mode_q  <= mode;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign cur_sel   = cur_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Directed bench for mux_scan_nto1: three instances cover the 4-channel
// DWELL=1 case, an 8-bit DWELL=3 case and a 5-channel non-power-of-2 case.
module tb_mux_scan_nto1;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  // Instance a: N_CH=4, DATA_W=1, DWELL=1
  logic [3:0]  a_d;
  logic [1:0]  a_sel, a_cur;
  logic        a_mode, a_en, a_out, a_valid, a_wrap;
  // Instance b: N_CH=4, DATA_W=8, DWELL=3
  logic [31:0] b_d;
  logic [1:0]  b_sel, b_cur;
  logic        b_mode, b_en, b_valid, b_wrap;
  logic [7:0]  b_out;
  // Instance c: N_CH=5, DATA_W=1, SEL_W=3, DWELL=1
  logic [4:0]  c_d;
  logic [2:0]  c_sel, c_cur;
  logic        c_mode, c_en, c_out, c_valid, c_wrap;

  mux_scan_nto1 #(.N_CH(4), .DATA_W(1), .SEL_W(2), .DWELL(1)) u_a (
    .clk(clk), .rst_n(rst_n), .d(a_d), .sel(a_sel), .mode(a_mode), .en(a_en),
    .out(a_out), .out_valid(a_valid), .cur_sel(a_cur), .wrap(a_wrap)
  );

  mux_scan_nto1 #(.N_CH(4), .DATA_W(8), .SEL_W(2), .DWELL(3)) u_b (
    .clk(clk), .rst_n(rst_n), .d(b_d), .sel(b_sel), .mode(b_mode), .en(b_en),
    .out(b_out), .out_valid(b_valid), .cur_sel(b_cur), .wrap(b_wrap)
  );

  mux_scan_nto1 #(.N_CH(5), .DATA_W(1), .SEL_W(3), .DWELL(1)) u_c (
    .clk(clk), .rst_n(rst_n), .d(c_d), .sel(c_sel), .mode(c_mode), .en(c_en),
    .out(c_out), .out_valid(c_valid), .cur_sel(c_cur), .wrap(c_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_mode = 1'b1; a_en = 1'b1; a_d = 4'hF; a_sel = 2'd3;
    b_mode = 1'b1; b_en = 1'b1; b_d = '1;   b_sel = 2'd3;
    c_mode = 1'b1; c_en = 1'b1; c_d = '1;   c_sel = 3'd4;
    step;
    n_chk++;
    if ({a_out, a_cur, a_valid, a_wrap} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_a: got %b want 00000", {a_out, a_cur, a_valid, a_wrap});
    end
    n_chk++;
    if ({b_out, b_cur, b_valid, b_wrap} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_b: got %h want 000", {b_out, b_cur, b_valid, b_wrap});
    end
    n_chk++;
    if ({c_out, c_cur, c_valid, c_wrap} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_c: got %b want 000000", {c_out, c_cur, c_valid, c_wrap});
    end
    rst_n = 1'b1;
    a_mode = 1'b0; a_en = 1'b0;
    b_mode = 1'b0; b_en = 1'b0;
    c_mode = 1'b0; c_en = 1'b0;
    step;
  endtask

  task automatic test_manual;
    logic [3:0] dv;
    logic [4:0] exp;
    dv = 4'b1010;
    a_d = dv; a_mode = 1'b0; a_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_sel = 2'(i);
      step;
      exp = {dv[i], 2'(i), 1'b1, 1'b0};
      n_chk++;
      if ({a_out, a_cur, a_valid, a_wrap} !== exp) begin
        n_fail++;
        $display("FAIL manual sel=%0d: got %b want %b", i, {a_out, a_cur, a_valid, a_wrap}, exp);
      end
    end
  endtask

  task automatic test_scan_dwell1;
    logic [3:0] dv;
    logic [4:0] exp;
    dv = 4'b1010;
    a_d = dv; a_mode = 1'b1; a_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step;
      exp = {dv[i%4], 2'(i % 4), 1'b1, (i % 4 == 3)};
      n_chk++;
      if ({a_out, a_cur, a_valid, a_wrap} !== exp) begin
        n_fail++;
        $display("FAIL scan1 cyc=%0d: got %b want %b", i, {a_out, a_cur, a_valid, a_wrap}, exp);
      end
    end
  endtask

  task automatic test_hold_mode_switch;
    logic [4:0] exp;
    // Channel 2 is the only high input so the frozen value is distinguishable.
    a_d = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step;
      exp = {(i == 2), 2'(i), 1'b1, 1'b0};
      n_chk++;
      if ({a_out, a_cur, a_valid, a_wrap} !== exp) begin
        n_fail++;
        $display("FAIL prehold cyc=%0d: got %b want %b", i, {a_out, a_cur, a_valid, a_wrap}, exp);
      end
    end
    a_en = 1'b0; a_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step;
      n_chk++;
      if ({a_out, a_cur, a_valid, a_wrap} !== 5'b1_10_0_0) begin
        n_fail++;
        $display("FAIL hold cyc=%0d: got %b want 11000", i, {a_out, a_cur, a_valid, a_wrap});
      end
    end
    a_en = 1'b1; a_mode = 1'b0; a_sel = 2'd1; a_d = 4'b1010;
    step;
    n_chk++;
    if ({a_out, a_cur, a_valid, a_wrap} !== 5'b1_01_1_0) begin
      n_fail++;
      $display("FAIL to_manual: got %b want 10110", {a_out, a_cur, a_valid, a_wrap});
    end
    a_mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step;
      exp = {(i == 1), 2'(i), 1'b1, 1'b0};
      n_chk++;
      if ({a_out, a_cur, a_valid, a_wrap} !== exp) begin
        n_fail++;
        $display("FAIL rescan cyc=%0d: got %b want %b", i, {a_out, a_cur, a_valid, a_wrap}, exp);
      end
    end
    a_en = 1'b0;
  endtask

  task automatic test_dwell3;
    logic [7:0]  tbl [4];
    logic [11:0] exp;
    int          ch;
    tbl[0] = 8'hAA; tbl[1] = 8'hBB; tbl[2] = 8'hCC; tbl[3] = 8'hDD;
    b_d = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; b_mode = 1'b1; b_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step;
      ch  = (i / 3) % 4;
      exp = {tbl[ch], 2'(ch), 1'b1, (i == 11)};
      n_chk++;
      if ({b_out, b_cur, b_valid, b_wrap} !== exp) begin
        n_fail++;
        $display("FAIL scan3 cyc=%0d: got %h want %h", i, {b_out, b_cur, b_valid, b_wrap}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_scan;
    logic [11:0] exp;
    // Advance to the first dwell cycle of channel 3 (dcnt now 1).
    for (int i = 13; i < 22; i++) step;
    n_chk++;
    if ({b_out, b_cur, b_valid, b_wrap} !== {8'hDD, 2'd3, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL premid: got %h want %h", {b_out, b_cur, b_valid, b_wrap},
               {8'hDD, 2'd3, 1'b1, 1'b0});
    end
    rst_n = 1'b0;
    step;
    n_chk++;
    if ({b_out, b_cur, b_valid, b_wrap} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h want 000", {b_out, b_cur, b_valid, b_wrap});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      exp = (i < 3) ? {8'hAA, 2'd0, 1'b1, 1'b0} : {8'hBB, 2'd1, 1'b1, 1'b0};
      n_chk++;
      if ({b_out, b_cur, b_valid, b_wrap} !== exp) begin
        n_fail++;
        $display("FAIL postrst cyc=%0d: got %h want %h", i, {b_out, b_cur, b_valid, b_wrap}, exp);
      end
    end
    b_en = 1'b0;
  endtask

  task automatic test_npow2;
    logic [4:0] dv;
    logic [5:0] exp;
    dv = 5'b10110;
    c_d = dv; c_mode = 1'b0; c_en = 1'b1; c_sel = 3'd4;
    step;
    n_chk++;
    if ({c_out, c_cur, c_valid, c_wrap} !== 6'b1_100_1_0) begin
      n_fail++;
      $display("FAIL np2 sel=4: got %b want 110010", {c_out, c_cur, c_valid, c_wrap});
    end
    for (int s = 5; s < 8; s++) begin
      c_sel = 3'(s);
      step;
      n_chk++;
      if ({c_out, c_cur, c_valid, c_wrap} !== 6'b1_100_0_0) begin
        n_fail++;
        $display("FAIL np2 sel=%0d: got %b want 110000", s, {c_out, c_cur, c_valid, c_wrap});
      end
    end
    c_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step;
      exp = {dv[i%5], 3'(i % 5), 1'b1, (i % 5 == 4)};
      n_chk++;
      if ({c_out, c_cur, c_valid, c_wrap} !== exp) begin
        n_fail++;
        $display("FAIL np2 scan cyc=%0d: got %b want %b", i, {c_out, c_cur, c_valid, c_wrap}, exp);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    test_reset;
    test_manual;
    test_scan_dwell1;
    test_hold_mode_switch;
    test_dwell3;
    test_reset_mid_scan;
    test_npow2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
